// File: rtl/riscv_dbus_master.sv
// riscv_dbus_master
// Data-bus master for the M stage. Converts M-stage loads/stores into single
// outstanding req/gnt/rvalid transactions, stalls the pipeline while one is in
// flight, aligns/extends load data, builds store byte enables and flags
// misaligned, illegal and timed-out accesses.
//
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   i_ld_enM, i_st_enM         load / store in M (load wins if both set)
//   i_funct3M                  size/sign code (B, H, W, BU, HU)
//   i_addrM, i_st_dataM        byte address, store data
//   o_bus_stallM               stall request to the hazard unit
//   o_ld_dataM                 aligned, extended load result
//   o_bus_err                  misaligned / illegal / timeout indication
//   o_bus_req/we/addr/wdata/be address phase towards the data bus
//   i_bus_gnt, i_bus_rvalid    bus handshake
//   i_bus_rdata                read data
//
// state | meaning
// IDLE  | waiting for an M-stage access; legal access launches (stall)
// REQ   | o_bus_req high until gnt (stall)
// RESP  | waiting for rvalid (stall)
// DONE  | one stall-free cycle so the M register advances
module riscv_dbus_master #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ld_enM,
  input  logic        i_st_enM,
  input  logic [2:0]  i_funct3M,
  input  logic [31:0] i_addrM,
  input  logic [31:0] i_st_dataM,
  output logic        o_bus_stallM,
  output logic [31:0] o_ld_dataM,
  output logic        o_bus_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic          tmo_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;

  logic        access;
  logic        f3_ok;
  logic        align_ok;
  logic        launch;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;

  always_comb begin
    access   = i_ld_enM | i_st_enM;
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    if (i_ld_enM) begin
      f3_ok = (i_funct3M == 3'b000) || (i_funct3M == 3'b001) || (i_funct3M == 3'b010) ||
              (i_funct3M == 3'b100) || (i_funct3M == 3'b101);
    end else begin
      f3_ok = (i_funct3M == 3'b000) || (i_funct3M == 3'b001) || (i_funct3M == 3'b010);
    end
    case (i_funct3M[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~i_addrM[0];
      2'b10:   align_ok = (i_addrM[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    launch = (state_q == S_IDLE) && access && f3_ok && align_ok;

    be_new    = 4'b1111;
    wdata_new = i_st_dataM;
    case (i_funct3M[1:0])
      2'b00: begin
        be_new    = 4'b0001 << i_addrM[1:0];
        wdata_new = {4{i_st_dataM[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << i_addrM[1:0];
        wdata_new = {2{i_st_dataM[15:0]}};
      end
      default: ;
    endcase

    ld_shift = i_bus_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Stall and error are gated by rst_n so they drop asynchronously with reset
  // even if an access is still presented in M.
  assign o_bus_req    = (state_q == S_REQ);
  assign o_bus_stallM = rst_n & (launch | (state_q == S_REQ) | (state_q == S_RESP));
  assign o_bus_err    = rst_n & (((state_q == S_IDLE) & access & ~(f3_ok & align_ok)) |
                                 ((state_q == S_DONE) & tmo_q));

  // cnt_q counts down from TIMEOUT_CYC; reaching zero without the awaited
  // handshake aborts the access. A handshake in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= 32'd0;
      o_bus_wdata <= 32'd0;
      o_bus_be    <= 4'd0;
      o_ld_dataM  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            state_q     <= S_REQ;
            cnt_q       <= TMO_LOAD;
            tmo_q       <= 1'b0;
            f3_q        <= i_funct3M;
            off_q       <= i_addrM[1:0];
            o_bus_we    <= ~i_ld_enM;
            o_bus_addr  <= {i_addrM[31:2], 2'b00};
            o_bus_wdata <= wdata_new;
            o_bus_be    <= be_new;
          end
        end
        S_REQ: begin
          if (i_bus_gnt) begin
            state_q <= S_RESP;
            cnt_q   <= TMO_LOAD;
          end else if (cnt_q == '0) begin
            state_q <= S_DONE;
            tmo_q   <= 1'b1;
            if (!o_bus_we) o_ld_dataM <= 32'd0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_RESP: begin
          if (i_bus_rvalid) begin
            state_q <= S_DONE;
            if (!o_bus_we) o_ld_dataM <= ld_ext;
          end else if (cnt_q == '0) begin
            state_q <= S_DONE;
            tmo_q   <= 1'b1;
            if (!o_bus_we) o_ld_dataM <= 32'd0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dbus_master.sv
module tb_riscv_dbus_master;

  localparam int TMO   = 8;
  localparam int NEVER = -1;
  localparam int BOUND = 4 * TMO + 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_ld_enM = 1'b0, i_st_enM = 1'b0;
  logic [2:0]  i_funct3M = 3'b000;
  logic [31:0] i_addrM = 32'd0, i_st_dataM = 32'd0;
  logic        o_bus_stallM, o_bus_err, o_bus_req, o_bus_we;
  logic [31:0] o_ld_dataM, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_gnt = 1'b0, i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = 32'd0;

  riscv_dbus_master #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ld_enM(i_ld_enM), .i_st_enM(i_st_enM), .i_funct3M(i_funct3M),
    .i_addrM(i_addrM), .i_st_dataM(i_st_dataM),
    .o_bus_stallM(o_bus_stallM), .o_ld_dataM(o_ld_dataM), .o_bus_err(o_bus_err),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
    .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          illegal;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
    bit          err;
    int          stall;
  } exp_t;

  typedef struct {
    int          g;
    int          r;
    logic [31:0] rdata;
  } rsp_t;

  exp_t sb[$];
  rsp_t rq[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b1;
  bit   stray_en = 1'b1;
  logic [31:0] last_ld = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic bit rbit();
    return stray_en && ($urandom_range(0, 1) == 1);
  endfunction

  // Reference model: access width in bytes from funct3, 0 when unknown.
  function automatic int width_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit legal_of(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int w;
    w = width_of(f3);
    if (w == 0) return 1'b0;
    if (!ld && f3 > 3'd2) return 1'b0;
    return (a % w) == 0;
  endfunction

  function automatic logic [31:0] load_of(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
    int w, off;
    logic [31:0] v, mask;
    w    = width_of(f3);
    off  = a % 4;
    v    = rd >> (8 * off);
    mask = (w == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * w)) - 32'h1);
    v    = v & mask;
    if (w < 4 && f3 < 3'd4 && v[8*w-1]) v = v | ~mask;
    return v;
  endfunction

  // Present one M-stage instruction and hold it until the pipeline advances.
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int g, input int r, input logic [31:0] rd);
    exp_t e;
    rsp_t q;
    int   n, w;
    bit   s;
    i_ld_enM = ld; i_st_enM = st; i_funct3M = f3; i_addrM = a; i_st_dataM = d;
    if (ld || st) begin
      e.we = !ld;
      e.addr = {a[31:2], 2'b00};
      e.be = 4'd0; e.wdata = 32'd0; e.err = 1'b0; e.stall = 0; e.ld = last_ld;
      if (!legal_of(ld, f3, a)) begin
        e.illegal = 1'b1; e.err = 1'b1;
      end else begin
        e.illegal = 1'b0;
        w = width_of(f3);
        e.be = 4'(((1 << w) - 1) << (a % 4));
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % w) +: 8];
        e.err   = (g == NEVER) || (r == NEVER);
        e.stall = 1 + ((g == NEVER) ? TMO + 1 : g + 1 + ((r == NEVER) ? TMO + 1 : r + 1));
        if (ld) begin
          e.ld = e.err ? 32'd0 : load_of(f3, a, rd);
          last_ld = e.ld;
        end
        q.g = g; q.r = r; q.rdata = rd;
        rq.push_back(q);
      end
      sb.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk); s = o_bus_stallM;
      @(posedge clk); #1; n++;
    end while (s && n < BOUND);
    if (s) begin
      failures++;
      $display("FAIL stall_bound actual=%0d required<%0d", n, BOUND);
    end
  endtask

  // Bus slave: grant after g REQ cycles, respond r RESP cycles later; stray
  // handshakes are sprinkled where the master must ignore them.
  initial begin : responder
    rsp_t d;
    int   k;
    bit   granted;
    forever begin
      @(posedge clk); #1;
      if (!o_bus_req) begin
        i_bus_gnt = rbit(); i_bus_rvalid = rbit(); i_bus_rdata = $urandom;
      end else begin
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req actual=1 required=0");
          d.g = 0; d.r = 0; d.rdata = 32'd0;
        end else d = rq.pop_front();
        k = 0; granted = 1'b0;
        forever begin
          i_bus_gnt = (k == d.g); i_bus_rvalid = rbit(); i_bus_rdata = $urandom;
          @(posedge clk); #1;
          if (k == d.g) begin granted = 1'b1; break; end
          if (k == TMO) break;
          k++;
        end
        i_bus_gnt = 1'b0;
        if (granted) begin
          k = 0;
          forever begin
            i_bus_rvalid = (k == d.r);
            i_bus_rdata  = (k == d.r) ? d.rdata : $urandom;
            i_bus_gnt    = rbit();
            @(posedge clk); #1;
            if (k == d.r || k == TMO) break;
            k++;
          end
        end
        i_bus_gnt = rbit(); i_bus_rvalid = rbit(); i_bus_rdata = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard at the first REQ cycle, at DONE (stall falls)
  // and on an IDLE error pulse.
  initial begin : monitor
    exp_t cur;
    bit   prev_stall = 1'b0;
    bit   in_txn = 1'b0;
    int   cnt = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        prev_stall = 1'b0; in_txn = 1'b0; cnt = 0;
      end else begin
        if (o_bus_stallM) begin
          cnt++;
          if (o_bus_req && !in_txn) begin
            in_txn = 1'b1;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL sb_empty_req actual=0 required=1");
            end else cur = sb.pop_front();
          end
          if (in_txn) begin
            chk("bus_we", 32'(o_bus_we), 32'(cur.we));
            chk("bus_addr", o_bus_addr, cur.addr);
            chk("bus_be", 32'(o_bus_be), 32'(cur.be));
            if (cur.we) chk("bus_wdata", o_bus_wdata, cur.wdata);
          end
        end else begin
          chk("req_no_stall", 32'(o_bus_req), 32'd0);
          if (prev_stall) begin
            if (!in_txn) begin
              failures++;
              $display("FAIL no_req_seen actual=0 required=1");
            end
            chk("stall_cycles", 32'(cnt), 32'(cur.stall));
            chk("done_err", 32'(o_bus_err), 32'(cur.err));
            chk("ld_data", o_ld_dataM, cur.ld);
            in_txn = 1'b0;
          end else if (o_bus_err) begin
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL sb_empty_err actual=0 required=1");
            end else begin
              cur = sb.pop_front();
              chk("illegal_flag", 32'(cur.illegal), 32'd1);
              chk("illegal_ld_hold", o_ld_dataM, cur.ld);
            end
          end
          cnt = 0;
        end
        prev_stall = o_bus_stallM;
      end
    end
  end

  initial begin : driver
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind, g, r, n;
    #7;
    chk("rst_stall", 32'(o_bus_stallM), 32'd0);
    chk("rst_req", 32'(o_bus_req), 32'd0);
    chk("rst_err", 32'(o_bus_err), 32'd0);
    chk("rst_we", 32'(o_bus_we), 32'd0);
    chk("rst_addr", o_bus_addr, 32'd0);
    chk("rst_wdata", o_bus_wdata, 32'd0);
    chk("rst_be", 32'(o_bus_be), 32'd0);
    chk("rst_ld", o_ld_dataM, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1, 0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    issue(1, 0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h8012_3456);
    issue(1, 0, 3'd4, 32'h103, 32'h0, 1, 2, 32'h8012_3456);
    issue(1, 0, 3'd1, 32'h102, 32'h0, 0, 1, 32'h8001_5555);
    issue(0, 1, 3'd0, 32'h201, 32'h1234_56AB, 0, 0, 32'h0);
    issue(0, 1, 3'd1, 32'h202, 32'h1234_56AB, 2, 0, 32'h0);
    issue(1, 0, 3'd2, 32'h102, 32'h0, 0, 0, 32'h0);
    issue(1, 0, 3'd3, 32'h100, 32'h0, 0, 0, 32'h0);
    issue(1, 1, 3'd2, 32'h104, 32'h5555_5555, 4, 6, 32'hCAFE_F00D);
    issue(1, 0, 3'd2, 32'h108, 32'h0, NEVER, 0, 32'h0);
    issue(1, 0, 3'd1, 32'h10A, 32'h0, 0, NEVER, 32'h0);
    issue(0, 1, 3'd4, 32'h10C, 32'h0, 0, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      g = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, TMO - 1);
      r = ($urandom_range(0, 6) == 0) ? NEVER : $urandom_range(0, TMO - 1);
      issue(kind >= 1 && kind <= 5, kind >= 4, f3, a, $urandom, g, r, $urandom);
    end
    issue(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h0);
    n = 0;
    while ((sb.size() != 0 || rq.size() != 0) && n < BOUND) begin
      @(posedge clk); n++;
    end
    chk("sb_drained", 32'(sb.size() + rq.size()), 32'd0);

    // Reset in RESP: request and stall drop immediately, stray rvalid later is ignored.
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0; stray_en = 1'b0;
    rq.push_back('{g: 0, r: NEVER, rdata: 32'h0});
    i_ld_enM = 1'b1; i_st_enM = 1'b0; i_funct3M = 3'd2; i_addrM = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("resp_req", 32'(o_bus_req), 32'd0);
    chk("resp_stall", 32'(o_bus_stallM), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(o_bus_req), 32'd0);
    chk("rst_mid_stall", 32'(o_bus_stallM), 32'd0);
    chk("rst_mid_ld", o_ld_dataM, 32'd0);
    i_ld_enM = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (TMO + 6) @(posedge clk);
    @(negedge clk);
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #2;
    i_bus_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rvalid_ld", o_ld_dataM, 32'd0);
    chk("stray_rvalid_stall", 32'(o_bus_stallM), 32'd0);
    chk("stray_rvalid_req", 32'(o_bus_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
